// File: rtl/pokey_audio_mixer.sv
// pokey_audio_mixer
// Mixes NCH unsigned channel volumes through a registered binary adder tree, with per-channel
// mute and left/right pan registers, and drives a first-order sigma-delta DAC from the mono sum.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enn        clock enable; every register advances only on enabled edges
//   aud_in     channel volumes, channel i at [i*AW +: AW]
//   reg_we     register write strobe
//   reg_sel    0 = mute register, 1 = pan register
//   reg_wdata  register write data
//   mute_q     mute register (bit i = 1 silences channel i)
//   pan_q      pan register (bit i = 1 routes channel i right)
//   audio      mono sum of unmuted channels
//   audio_l    sum of unmuted channels panned left
//   audio_r    sum of unmuted channels panned right
//   dac_out    sigma-delta bitstream of audio
module pokey_audio_mixer #(
    parameter int unsigned    NCH     = 4,
    parameter int unsigned    AW      = 4,
    parameter logic [NCH-1:0] PAN_RST = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enn,
    input  logic [NCH*AW-1:0]           aud_in,
    input  logic                        reg_we,
    input  logic                        reg_sel,
    input  logic [NCH-1:0]              reg_wdata,
    output logic [NCH-1:0]              mute_q,
    output logic [NCH-1:0]              pan_q,
    output logic [AW+$clog2(NCH)-1:0]   audio,
    output logic [AW+$clog2(NCH)-1:0]   audio_l,
    output logic [AW+$clog2(NCH)-1:0]   audio_r,
    output logic                        dac_out
);

    localparam int unsigned LV = $clog2(NCH);
    localparam int unsigned OW = AW + LV;
    localparam int unsigned NP = 1 << LV;     // leaves after zero-padding to a power of two
    localparam int unsigned NN = 2 * NP - 1;  // nodes in the heap-ordered tree

    // Heap layout: node 0 is the root, node i has children 2i+1 and 2i+2, leaves sit at
    // NP-1 .. NN-1. Every node is one register, so a leaf reaches the root after LV edges.
    // All nodes carry OW bits; the sum can never exceed that width.
    logic [OW-1:0] mono_q  [NN];
    logic [OW-1:0] left_q  [NN];
    logic [OW-1:0] right_q [NN];

    logic [OW-1:0] leaf_m [NP];
    logic [OW-1:0] leaf_l [NP];
    logic [OW-1:0] leaf_r [NP];

    logic [OW:0]   acc_q;

    // Masked leaf values; padding leaves beyond NCH stay zero.
    always_comb begin
        for (int c = 0; c < NP; c++) begin
            leaf_m[c] = '0;
            leaf_l[c] = '0;
            leaf_r[c] = '0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (!mute_q[c]) begin
                leaf_m[c] = OW'(aud_in[c*AW +: AW]);
                if (pan_q[c]) begin
                    leaf_r[c] = OW'(aud_in[c*AW +: AW]);
                end else begin
                    leaf_l[c] = OW'(aud_in[c*AW +: AW]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_q <= '0;
            pan_q  <= PAN_RST;
            acc_q  <= '0;
            for (int i = 0; i < NN; i++) begin
                mono_q[i]  <= '0;
                left_q[i]  <= '0;
                right_q[i] <= '0;
            end
        end else if (enn) begin
            // Leaves are loaded from the pre-write mute/pan values on a same-edge write.
            if (reg_we) begin
                if (reg_sel) begin
                    pan_q <= reg_wdata;
                end else begin
                    mute_q <= reg_wdata;
                end
            end
            for (int i = 0; i < NP - 1; i++) begin
                mono_q[i]  <= mono_q[2*i+1]  + mono_q[2*i+2];
                left_q[i]  <= left_q[2*i+1]  + left_q[2*i+2];
                right_q[i] <= right_q[2*i+1] + right_q[2*i+2];
            end
            for (int c = 0; c < NP; c++) begin
                mono_q[NP-1+c]  <= leaf_m[c];
                left_q[NP-1+c]  <= leaf_l[c];
                right_q[NP-1+c] <= leaf_r[c];
            end
            // Carry out of the OW-bit residue is the DAC bit; the carry is dropped next edge.
            acc_q <= {1'b0, acc_q[OW-1:0]} + {1'b0, mono_q[0]};
        end
    end

    assign audio   = mono_q[0];
    assign audio_l = left_q[0];
    assign audio_r = right_q[0];
    assign dac_out = acc_q[OW];

endmodule

// File: tb/tb_pokey_audio_mixer.sv
module tb_pokey_audio_mixer;

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned OW  = 6;

    typedef struct packed {
        logic [OW-1:0] m;
        logic [OW-1:0] l;
        logic [OW-1:0] r;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              enn;
    logic [NCH*AW-1:0] aud_in;
    logic              reg_we;
    logic              reg_sel;
    logic [NCH-1:0]    reg_wdata;
    logic [NCH-1:0]    mute_q;
    logic [NCH-1:0]    pan_q;
    logic [OW-1:0]     audio;
    logic [OW-1:0]     audio_l;
    logic [OW-1:0]     audio_r;
    logic              dac_out;

    // Three-channel build sharing clock, reset, enable and the low channels.
    logic [3*AW-1:0]   aud3;
    logic [2:0]        mute3;
    logic [2:0]        pan3;
    logic [OW-1:0]     audio3;
    logic [OW-1:0]     audio3_l;
    logic [OW-1:0]     audio3_r;
    logic              dac3;

    int unsigned n_total;
    int unsigned n_bad;

    exp_t          q[$];
    logic [OW-1:0] q3[$];
    exp_t          last;
    logic [OW-1:0] last3;
    logic [NCH-1:0] m_mute;
    logic [NCH-1:0] m_pan;

    assign aud3 = aud_in[3*AW-1:0];

    pokey_audio_mixer #(
        .NCH     (NCH),
        .AW      (AW),
        .PAN_RST (4'b0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enn       (enn),
        .aud_in    (aud_in),
        .reg_we    (reg_we),
        .reg_sel   (reg_sel),
        .reg_wdata (reg_wdata),
        .mute_q    (mute_q),
        .pan_q     (pan_q),
        .audio     (audio),
        .audio_l   (audio_l),
        .audio_r   (audio_r),
        .dac_out   (dac_out)
    );

    pokey_audio_mixer #(
        .NCH     (3),
        .AW      (AW),
        .PAN_RST (3'b000)
    ) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enn       (enn),
        .aud_in    (aud3),
        .reg_we    (1'b0),
        .reg_sel   (1'b0),
        .reg_wdata (3'b000),
        .mute_q    (mute3),
        .pan_q     (pan3),
        .audio     (audio3),
        .audio_l   (audio3_l),
        .audio_r   (audio3_r),
        .dac_out   (dac3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [NCH*AW-1:0] a, input logic [NCH-1:0] mu,
                                   input logic [NCH-1:0] pa);
        exp_t e;
        logic [AW-1:0] v;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            v = a[c*AW +: AW];
            if (!mu[c]) begin
                e.m = e.m + {2'b00, v};
                if (pa[c]) e.r = e.r + {2'b00, v};
                else       e.l = e.l + {2'b00, v};
            end
        end
        return e;
    endfunction

    function automatic logic [OW-1:0] model3(input logic [NCH*AW-1:0] a);
        logic [OW-1:0] s;
        s = '0;
        for (int c = 0; c < 3; c++) begin
            s = s + {2'b00, a[c*AW +: AW]};
        end
        return s;
    endfunction

    // One clock with the currently driven inputs; checks outputs #1 after the edge.
    task automatic tick();
        if (enn) begin
            q.push_back(model(aud_in, m_mute, m_pan));
            q3.push_back(model3(aud_in));
            if (reg_we) begin
                if (reg_sel) m_pan = reg_wdata;
                else         m_mute = reg_wdata;
            end
        end
        @(posedge clk);
        #1;
        if (enn) begin
            last  = q.pop_front();
            last3 = q3.pop_front();
        end
        check_eq("audio",    audio,    last.m);
        check_eq("audio_l",  audio_l,  last.l);
        check_eq("audio_r",  audio_r,  last.r);
        check_eq("mute_q",   mute_q,   m_mute);
        check_eq("pan_q",    pan_q,    m_pan);
        check_eq("audio3",   audio3,   last3);
        check_eq("audio3_l", audio3_l, last3);
        check_eq("audio3_r", audio3_r, 0);
    endtask

    task automatic wr(input logic sel, input logic [NCH-1:0] data);
        reg_we    = 1'b1;
        reg_sel   = sel;
        reg_wdata = data;
        tick();
        reg_we    = 1'b0;
    endtask

    // Asserts reset off-edge, checks outputs clear immediately and stay clear while held.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_now_audio", audio, 0);
        check_eq("rst_now_l",     audio_l, 0);
        check_eq("rst_now_r",     audio_r, 0);
        check_eq("rst_now_dac",   dac_out, 0);
        for (int i = 0; i < 3; i++) begin
            aud_in = NCH*AW'($urandom);
            @(posedge clk);
            #1;
            check_eq("rst_audio",  audio, 0);
            check_eq("rst_l",      audio_l, 0);
            check_eq("rst_r",      audio_r, 0);
            check_eq("rst_dac",    dac_out, 0);
            check_eq("rst_mute",   mute_q, 0);
            check_eq("rst_pan",    pan_q, 0);
            check_eq("rst_audio3", audio3, 0);
        end
        m_mute = '0;
        m_pan  = '0;
        q.delete();
        q3.delete();
        repeat (2) begin
            q.push_back('0);
            q3.push_back('0);
        end
        last  = '0;
        last3 = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned ones;
        int unsigned dac_vals [3];
        logic [NCH*AW-1:0] dac_pats [3];

        n_total   = 0;
        n_bad     = 0;
        enn       = 1'b0;
        reg_we    = 1'b0;
        reg_sel   = 1'b0;
        reg_wdata = '0;
        aud_in    = '0;
        rst_n     = 1'b1;
        #3;
        do_reset();

        // Full scale, pan left: 60 on mono/left exactly three edges after capture.
        enn    = 1'b1;
        aud_in = 16'hFFFF;
        repeat (4) tick();

        // Pan 1010 with channels {4,3,2,1}: left 4, right 6, mono 10.
        wr(1'b1, 4'b1010);
        aud_in = 16'h4321;
        repeat (4) tick();

        // Mute ch0 on the same edge as a full-scale capture: that sample is still 60.
        aud_in = 16'hFFFF;
        wr(1'b1, 4'b0000);
        wr(1'b0, 4'b0001);
        repeat (4) tick();

        // Enable one cycle in four; writes while disabled must be ignored.
        for (int i = 0; i < 24; i++) begin
            enn       = (i % 4 == 0);
            aud_in    = NCH*AW'($urandom);
            reg_we    = (i % 4 == 2);
            reg_sel   = 1'b0;
            reg_wdata = 4'hF;
            tick();
        end
        reg_we = 1'b0;
        enn    = 1'b1;

        // Random traffic with occasional mute/pan writes.
        for (int i = 0; i < 20; i++) begin
            aud_in    = NCH*AW'($urandom);
            reg_we    = ($urandom_range(0, 3) == 0);
            reg_sel   = 1'($urandom);
            reg_wdata = NCH'($urandom);
            tick();
        end
        reg_we = 1'b0;

        // Sigma-delta density over 64 enabled edges with a settled input.
        wr(1'b0, 4'b0000);
        wr(1'b1, 4'b0000);
        dac_pats[0] = 16'h4444; dac_vals[0] = 16;
        dac_pats[1] = 16'hFFFF; dac_vals[1] = 60;
        dac_pats[2] = 16'h0000; dac_vals[2] = 0;
        for (int k = 0; k < 3; k++) begin
            aud_in = dac_pats[k];
            repeat (6) tick();
            ones = 0;
            repeat (64) begin
                tick();
                ones += dac_out;
            end
            check_eq("dac_ones", ones, dac_vals[k]);
        end

        // Reset with a full pipeline, then refill.
        aud_in = 16'hFFFF;
        repeat (3) tick();
        do_reset();
        aud_in = 16'h1234;
        repeat (4) tick();
        aud_in = 16'h9F0A;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
